// File: rtl/alu.sv
// alu -- single-cycle registered 32-bit ALU.
//
// Each operation has its own combinational unit: adder, subtractor,
// 16x16 multiplier, logic unit and signed compare. The function select
// picks one result, and r registers that result on every rising clk edge.
// There is no enable and no valid/ready handshake. The result for the
// inputs sampled at edge N appears on r just after edge N.
//
// Ports:
//   clk    in   1   clock; all state updates on its rising edge
//   rst_n  in   1   asynchronous active-low reset; forces r to 0 at once
//   a      in  32   operand A (unsigned, except for SLT which is signed)
//   b      in  32   operand B (unsigned, except for SLT which is signed)
//   f      in   3   function select (see op_e)
//   r      out 32   result register

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] r
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLT = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] mul_res;
  logic [31:0] and_res;
  logic [31:0] or_res;
  logic [31:0] xor_res;
  logic        slt_bit;
  logic [31:0] next_r;

  // Carry and borrow out of bit 31 are dropped by the 32-bit result width.
  assign add_res = a + b;
  assign sub_res = a - b;

  // The multiplier sees only the low halves. Zero-extending them to 32 bits
  // keeps the full 32-bit product.
  assign mul_res = {16'h0000, a[15:0]} * {16'h0000, b[15:0]};

  assign and_res = a & b;
  assign or_res  = a | b;
  assign xor_res = a ^ b;

  // This is the only signed operation.
  assign slt_bit = $signed(a) < $signed(b);

  always_comb begin
    next_r = 32'h0;
    case (op_e'(f))
      OP_ADD:  next_r = add_res;
      OP_SUB:  next_r = sub_res;
      OP_MUL:  next_r = mul_res;
      OP_AND:  next_r = and_res;
      OP_OR:   next_r = or_res;
      OP_XOR:  next_r = xor_res;
      OP_SLT:  next_r = {31'h0, slt_bit};
      OP_RSV:  next_r = 32'h0;
      default: next_r = 32'h0;
    endcase
  end

  // Reset clears r immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 32'h0;
    end else begin
      r <= next_r;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed and randomized checks of the alu result register.

module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  f;
  logic [31:0] r;

  int n_assert;
  int n_fail;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .f     (f),
    .r     (r)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, computed from the arithmetic meaning of each function.
  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mf);
    longint unsigned ua, ub;
    int sa, sb;
    ua = ma;
    ub = mb;
    sa = ma;
    sb = mb;
    case (mf)
      3'd0:    return 32'((ua + ub) % 64'h1_0000_0000);
      3'd1:    return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd2:    return 32'((ua % 65536) * (ub % 65536));
      3'd3:    return ma & mb;
      3'd4:    return ma | mb;
      3'd5:    return ma ^ mb;
      3'd6:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: place the inputs, wait for one edge, then check the registered result.
  task automatic apply(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [2:0] tf, input logic [31:0] exp);
    a = ta;
    b = tb_;
    f = tf;
    @(posedge clk);
    #1;
    check(tag, r, exp);
  endtask

  logic [31:0] sweep_exp [8];
  logic [31:0] ra, rb, exp_v;
  logic [2:0]  rf;

  initial begin
    sweep_exp = '{32'd5, 32'hFFFF_FFFF, 32'd6, 32'd2, 32'd3, 32'd1, 32'd1, 32'd0};
    n_assert = 0;
    n_fail   = 0;

    // Reset applied with no clock edge, then held across an edge, then released.
    rst_n = 1'b1;
    a = 32'd2;
    b = 32'd3;
    f = 3'd0;
    #1 rst_n = 1'b0;
    #1 check("reset_no_clk", r, 32'h0);
    @(posedge clk); #1;
    check("reset_held", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", r, 32'd5);

    // Opcode sweep with a=2, b=3.
    for (int i = 0; i < 8; i++) begin
      apply($sformatf("sweep_f%0d", i), 32'd2, 32'd3, 3'(i), sweep_exp[i]);
    end

    // Wrap cases
    apply("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'd0, 32'h0);
    apply("sub_wrap", 32'h0, 32'd1, 3'd1, 32'hFFFF_FFFF);

    // The multiplier uses only the low 16 bits of each operand.
    apply("mul_trunc", 32'h0001_0002, 32'hFFFF_0003, 3'd2, 32'd6);
    apply("mul_max", 32'h0000_FFFF, 32'h0000_FFFF, 3'd2, 32'hFFFE_0001);

    // Signed less-than
    apply("slt_neg_lt", 32'hFFFF_FFFF, 32'd1, 3'd6, 32'd1);
    apply("slt_pos_gt", 32'd1, 32'hFFFF_FFFF, 3'd6, 32'd0);
    apply("slt_equal", 32'h1234_5678, 32'h1234_5678, 3'd6, 32'd0);

    // Changes between edges are ignored. Only the last value before the edge counts.
    a = 32'd100; b = 32'd1; f = 3'd1;
    #2;
    check("between_edges_hold", r, 32'd0);
    a = 32'd7; b = 32'd9; f = 3'd0;
    @(posedge clk); #1;
    check("last_value_sampled", r, 32'd16);

    // Reset asserted in the middle of the sweep.
    apply("mid_sweep_f0", 32'd2, 32'd3, 3'd0, 32'd5);
    apply("mid_sweep_f1", 32'd2, 32'd3, 3'd1, 32'hFFFF_FFFF);
    a = 32'd2; b = 32'd3; f = 3'd2;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_immediate", r, 32'h0);
    @(posedge clk); #1;
    check("midrst_held_edge", r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    f = 3'd3;
    #1 check("midrst_released_no_edge", r, 32'h0);
    @(posedge clk); #1;
    check("midrst_first_edge", r, 32'd2);

    // Randomized operations against the model, with boundary operands mixed in.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'h7FFF_FFFF;
        default: rb = $urandom;
      endcase
      rf = 3'($urandom_range(0, 7));
      exp_v = model(ra, rb, rf);
      apply($sformatf("rand_%0d_f%0d", i, rf), ra, rb, rf, exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-004 a  input  32  Operand A, unsigned except where a signed operation is stated.
REQ-005 b  input  32  Operand B, unsigned except where a signed operation is stated.
REQ-006 f  input  3  Function select.
REQ-007 r  output  32  Result register.

Function
REQ-008 r SHALL be a register loaded on every rising clk edge while rst_n=1; there SHALL be no enable and no valid/ready handshake.
REQ-009 Latency SHALL be exactly one cycle: r after edge N reflects a, b and f sampled at edge N.
REQ-010 f=0 (ADD): r SHALL be (a+b) mod 2^32; carry-out discarded; no overflow flag.
REQ-011 f=1 (SUB): r SHALL be (a-b) mod 2^32, two's complement wrap; borrow discarded.
REQ-012 f=2 (MUL): r SHALL be the full 32-bit unsigned product a[15:0]*b[15:0]; a[31:16] and b[31:16] are ignored.
REQ-013 f=3 (AND): r SHALL be a & b, bitwise.
REQ-014 f=4 (OR): r SHALL be a | b, bitwise.
REQ-015 f=5 (XOR): r SHALL be a ^ b, bitwise.
REQ-016 f=6 (SLT): r SHALL be 32'h1 when a < b as signed two's complement, else 32'h0.
REQ-017 f=7 (reserved): r SHALL load 32'h0.
REQ-018 The result SHALL be selected combinationally from parallel units (adder, subtractor, 16x16 multiplier, logic unit) and then registered; no multi-cycle operations.
REQ-019 A change of f or the operands between edges SHALL have no effect on r until the next rising edge; the final pre-edge values are sampled.
REQ-020 X/Z on inputs is out of scope; the behaviour is unspecified.

Reset
REQ-021 While rst_n=0, r SHALL be 32'h0, asynchronously and immediately, regardless of clk.
REQ-022 On deassertion, the first rising edge with rst_n=1 SHALL load the result of the current a, b and f.
REQ-023 Assertion mid-stream SHALL discard the in-flight result; no result is retained across reset.

Verification
REQ-024 Reset: rst_n=0 with a=2, b=3, f=0 and no clk edge -> r=0; release, one edge -> r=5.
REQ-025 Opcode sweep a=2, b=3, f=0..7 on consecutive edges -> r = 5, 32'hFFFFFFFF, 6, 2, 3, 1, 1, 0, one cycle after each f.
REQ-026 Wrap: a=32'hFFFFFFFF, b=1 -> f=0 gives 0; a=0, b=1, f=1 -> 32'hFFFFFFFF.
REQ-027 MUL truncation: a=32'h00010002, b=32'hFFFF0003, f=2 -> r=6; a=b=32'h0000FFFF -> r=32'hFFFE0001.
REQ-028 SLT signed: a=32'hFFFFFFFF (-1), b=1, f=6 -> r=1; a=1, b=32'hFFFFFFFF -> r=0; a=b -> r=0.
REQ-029 Mid-run reset: assert rst_n between edges during the sweep -> r=0 at once and held; stays 0 until the first edge after release.
